// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with optional saturation and overflow/carry/zero/negative flags.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, part_q;
  logic             sat_q, cy_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] s_q;
  logic             ovf_q, carry_q, zero_q, neg_q;

  logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
  logic             co_ch, cin_msb, ovf_d;
  logic [WIDTH-1:0] raw_d, s_d;

  always_comb begin
    a_ch             = a_q[idx_q*CHUNK +: CHUNK];
    b_ch             = b_q[idx_q*CHUNK +: CHUNK];
    {co_ch, sum_ch}  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy_q};
    // Carry into the top bit of this chunk, recovered from its sum bit.
    cin_msb          = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum_ch[CHUNK-1];
    ovf_d            = cin_msb ^ co_ch;
    raw_d            = part_q;
    raw_d[WIDTH-1 -: CHUNK] = sum_ch;
    s_d              = raw_d;
    if (sat_q && ovf_d)
      s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      part_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            cy_q    <= sub;
            sat_q   <= sat;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          part_q[idx_q*CHUNK +: CHUNK] <= sum_ch;
          cy_q <= co_ch;
          if (idx_q == IW'(N-1)) begin
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            carry_q <= co_ch;
            zero_q  <= (s_d == '0);
            neg_q   <= s_d[WIDTH-1];
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s        = s_q;
  assign overflow = ovf_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign neg      = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: vector table, hand-written corner sequences and random ops
// against an arithmetic reference model, on an 8/4 and a 16/1 instance.
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st8 = 1'b0, st16 = 1'b0;
  logic        sub_i = 1'b0, sat_i = 1'b0;
  logic [15:0] a_i = '0, b_i = '0;

  logic        busy8, done8, ov8, c8, z8, n8;
  logic [7:0]  s8;
  logic        busy16, done16, ov16, c16, z16, n16;
  logic [15:0] s16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub_i), .sat(sat_i),
    .a(a_i[7:0]), .b(b_i[7:0]), .busy(busy8), .done(done8), .s(s8),
    .overflow(ov8), .carry(c8), .zero(z8), .neg(n8));

  addsub_seq #(.WIDTH(16), .CHUNK(1)) u16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sub_i), .sat(sat_i),
    .a(a_i), .b(b_i), .busy(busy16), .done(done16), .s(s16),
    .overflow(ov16), .carry(c16), .zero(z16), .neg(n16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, borrow as an unsigned compare.
  task automatic model(input int w, input logic [15:0] av, bv, input logic sv, tv,
                       output logic [15:0] so, output logic ov, c, z, n);
    longint mask, ua, ub, sa, sb, r, mx, mn, res;
    mask = (64'sd1 <<< w) - 1;
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    sa = (ua >= (64'sd1 <<< (w-1))) ? ua - (64'sd1 <<< w) : ua;
    sb = (ub >= (64'sd1 <<< (w-1))) ? ub - (64'sd1 <<< w) : ub;
    mx = (64'sd1 <<< (w-1)) - 1;
    mn = -(64'sd1 <<< (w-1));
    r  = sv ? sa - sb : sa + sb;
    ov = (r > mx) || (r < mn);
    c  = sv ? (ua >= ub) : ((ua + ub) > mask);
    res = r & mask;
    if (tv && ov) res = (sa < 0) ? (mn & mask) : mx;
    so = 16'(res);
    z  = (res == 0);
    n  = ((res >> (w-1)) & 1) != 0;
  endtask

  task automatic run_op(input bit wide, input logic [15:0] av, bv, input logic sv, tv,
                        input string tag, output logic [15:0] so,
                        output logic ov, c, z, n, output int lat);
    bit got = 0;
    int busy_err = 0;
    @(negedge clk);
    a_i = av; b_i = bv; sub_i = sv; sat_i = tv;
    if (wide) st16 = 1'b1; else st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; st16 = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      if ((wide ? busy16 : busy8) !== 1'b1) busy_err++;
      a_i = 16'($urandom); b_i = 16'($urandom);
      sub_i = 1'($urandom); sat_i = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (wide ? done16 : done8) got = 1;
    end
    chk({tag, " busy_while_running"}, 32'(busy_err), 32'd0);
    if (!got) chk({tag, " done_timeout"}, 32'(got), 32'd1);
    if (wide) begin so = s16; ov = ov16; c = c16; z = z16; n = n16; end
    else      begin so = {8'h0, s8}; ov = ov8; c = c8; z = z8; n = n8; end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(wide ? done16 : done8), 32'd0);
    chk({tag, " idle_after_done"}, 32'(wide ? busy16 : busy8), 32'd0);
  endtask

  typedef struct {
    string name;
    logic [7:0] a, b;
    logic sub, sat;
    logic [7:0] s;
    logic ov, c, z, n;
  } vec_t;

  initial begin
    vec_t tbl[8];
    logic [15:0] so, es;
    logic ov, c, z, n, eov, ec, ez, en;
    int lat, cnt;

    tbl[0] = '{"add_5_3",     8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{"add_ovf",     8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{"add_ovf_sat", 8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{"sub_ovf",     8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"sub_ovf_sat", 8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{"sub_zero",    8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{"add_wrap",    8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{"neg_ovf_sat", 8'h80, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state8",  {busy8, done8, s8, ov8, c8, z8, n8}, 32'd0);
    chk("reset_state16", {busy16, done16, s16, ov16, c16, z16, n16}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(0, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, tbl[i].sub, tbl[i].sat, tbl[i].name,
             so, ov, c, z, n, lat);
      chk({tbl[i].name, " latency"}, 32'(lat), 32'd2);
      chk({tbl[i].name, " s"}, 32'(so), 32'(tbl[i].s));
      chk({tbl[i].name, " flags"}, {ov, c, z, n}, {tbl[i].ov, tbl[i].c, tbl[i].z, tbl[i].n});
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    a_i = 16'h10; b_i = 16'h20; sub_i = 0; sat_i = 0; st8 = 1;
    @(negedge clk);
    a_i = 16'hFF; b_i = 16'hFF; st8 = 1;
    @(negedge clk);
    st8 = 0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (done8) begin
        cnt++;
        chk("busy_start s", 32'(s8), 32'h30);
      end
      @(negedge clk);
    end
    chk("busy_start done_count", 32'(cnt), 32'd1);

    // reset during the first RUN cycle discards the operation
    a_i = 16'h03; b_i = 16'h04; st8 = 1;
    @(negedge clk);
    st8 = 0; rst = 1;
    @(negedge clk);
    chk("mid_reset state", {busy8, done8, s8, ov8, c8, z8, n8}, 32'd0);
    rst = 0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (done8) cnt++; end
    chk("mid_reset no_done", 32'(cnt), 32'd0);
    run_op(0, 16'h01, 16'h01, 0, 0, "after_reset", so, ov, c, z, n, lat);
    chk("after_reset s", 32'(so), 32'h02);
    chk("after_reset latency", 32'(lat), 32'd2);

    // start held high: one op per IDLE visit, period N+2 = 4
    @(negedge clk);
    a_i = 16'h01; b_i = 16'h02; sub_i = 0; sat_i = 0; st8 = 1;
    cnt = 0;
    repeat (12) begin @(posedge clk); @(negedge clk); if (done8) cnt++; end
    st8 = 0;
    chk("held_start done_count", 32'(cnt), 32'd3);
    chk("held_start s", 32'(s8), 32'h03);
    repeat (4) @(negedge clk);

    // 16-bit, one bit per clock
    run_op(1, 16'h7FFF, 16'h0001, 0, 1, "w16_sat", so, ov, c, z, n, lat);
    chk("w16_sat latency", 32'(lat), 32'd16);
    chk("w16_sat s", 32'(so), 32'h7FFF);
    chk("w16_sat ovf", 32'(ov), 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic rs, rt;
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rt = 1'($urandom);
      if (i % 10 == 0) begin ra = 16'h0080; rb = 16'h0080; end
      model(8, ra, rb, rs, rt, es, eov, ec, ez, en);
      run_op(0, ra, rb, rs, rt, "rand8", so, ov, c, z, n, lat);
      chk("rand8 s", 32'(so), 32'(es));
      chk("rand8 flags", {ov, c, z, n}, {eov, ec, ez, en});
    end
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb;
      logic rs, rt;
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rt = 1'($urandom);
      model(16, ra, rb, rs, rt, es, eov, ec, ez, en);
      run_op(1, ra, rb, rs, rt, "rand16", so, ov, c, z, n, lat);
      chk("rand16 s", 32'(so), 32'(es));
      chk("rand16 flags", {ov, c, z, n}, {eov, ec, ez, en});
      chk("rand16 latency", 32'(lat), 32'd16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
